// File: rtl/imem_boot_loader_if.sv
// Byte-stream and instruction-memory write bundle for imem_boot_loader.
// slave = loader side, master = stream source / memory observer side.
interface imem_boot_loader_if #(
   parameter int ADDR_W = 6
);
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_waddr;
   logic [31:0]       imem_wdata;

   modport slave (
      input  byte_valid, byte_data,
      output byte_ready, imem_we, imem_waddr, imem_wdata
   );

   modport master (
      output byte_valid, byte_data,
      input  byte_ready, imem_we, imem_waddr, imem_wdata
   );
endinterface

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed little-endian word image into instruction memory
// and holds the CPU in reset until done. IMEM_BOOT_CHECKSUM_EN adds a trailing XOR byte check.
module imem_boot_loader #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   imem_boot_loader_if.slave bus,
   output logic            cpu_rst,
   output logic            done,
   output logic            err
);

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      WRITE,
`ifdef IMEM_BOOT_CHECKSUM_EN
      CHK,
`endif
      DONE,
      ERR
   } state_t;

`ifdef IMEM_BOOT_CHECKSUM_EN
   localparam state_t FIN_ST = CHK;
`else
   localparam state_t FIN_ST = DONE;
`endif

   localparam logic [15:0] DEPTH16 = 16'(DEPTH);

   state_t            state, state_nx;
   logic [15:0]       count;
   logic [ADDR_W:0]   widx;   // one extra bit so widx can reach DEPTH
   logic [ADDR_W:0]   widx_nx;
   logic [1:0]        lane;
   logic [31:0]       word;
   logic [15:0]       len_full;
   logic              xfer;
`ifdef IMEM_BOOT_CHECKSUM_EN
   logic [7:0]        xsum;
`endif

   assign xfer     = bus.byte_valid && bus.byte_ready;
   assign len_full = {bus.byte_data, count[7:0]};
   assign widx_nx  = widx + (ADDR_W+1)'(1);

`ifdef IMEM_BOOT_CHECKSUM_EN
   assign bus.byte_ready = (state == LEN_LO) || (state == LEN_HI) ||
                           (state == DATA)   || (state == CHK);
`else
   assign bus.byte_ready = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
`endif
   assign bus.imem_we    = (state == WRITE);
   assign bus.imem_waddr = widx[ADDR_W-1:0];
   assign bus.imem_wdata = word;
   assign cpu_rst        = (state != DONE);
   assign done           = (state == DONE);
   assign err            = (state == ERR);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE, ERR: if (start) state_nx = LEN_LO;
         LEN_LO:          if (xfer) state_nx = LEN_HI;
         LEN_HI: if (xfer) begin
            if (len_full == 16'd0)       state_nx = FIN_ST;
            else if (len_full > DEPTH16) state_nx = ERR;
            else                         state_nx = DATA;
         end
         DATA:  if (xfer && lane == 2'd3) state_nx = WRITE;
         WRITE: state_nx = (16'(widx_nx) == count) ? FIN_ST : DATA;
`ifdef IMEM_BOOT_CHECKSUM_EN
         CHK:   if (xfer) state_nx = (bus.byte_data == xsum) ? DONE : ERR;
`endif
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         count <= '0;
         widx  <= '0;
         lane  <= '0;
         word  <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
         xsum  <= '0;
`endif
      end else begin
         state <= state_nx;
         case (state)
            IDLE, DONE, ERR: if (start) begin
               widx <= '0;
               lane <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
               xsum <= '0;
`endif
            end
            LEN_LO: if (xfer) count[7:0]  <= bus.byte_data;
            LEN_HI: if (xfer) count[15:8] <= bus.byte_data;
            DATA: if (xfer) begin
               // first byte of a word lands in the LSB
               word[{lane, 3'b000} +: 8] <= bus.byte_data;
               lane <= lane + 2'd1;
`ifdef IMEM_BOOT_CHECKSUM_EN
               xsum <= xsum ^ bus.byte_data;
`endif
            end
            WRITE: widx <= widx_nx;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: vector table, hand-written corner
// sequences and randomized gapped loads against a spec-level image model.
module tb_imem_boot_loader;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic cpu_rst, done, err;

   imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
      .cpu_rst(cpu_rst), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit gaps = 1'b0;
   bit mid  = 1'b0;
   logic [7:0]  cks_flip = 8'h00;
   logic [31:0] img[$];
   logic [ADDR_W-1:0] qa[$];
   logic [31:0]       qd[$];

   typedef struct {
      int          cnt;
      logic [31:0] w0, w1, w2;
      bit          gap;
      bit          exp_done;
      int          exp_writes;
   } vec_t;

   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) begin
         qa.push_back(bus.imem_waddr);
         qd.push_back(bus.imem_wdata);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_byte_ready"}, 32'(bus.byte_ready), 0);
      chk({nm, "_imem_we"},    32'(bus.imem_we), 0);
      chk({nm, "_imem_waddr"}, 32'(bus.imem_waddr), 0);
      chk({nm, "_imem_wdata"}, bus.imem_wdata, 0);
      chk({nm, "_cpu_rst"},    32'(cpu_rst), 1);
      chk({nm, "_done"},       32'(done), 0);
      chk({nm, "_err"},        32'(err), 0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Present one byte and hold it until the loader takes it.
   task automatic send_byte(input logic [7:0] b);
      int n;
      if (gaps) begin
         int k;
         k = $urandom_range(0, 3);
         repeat (k) begin
            start = mid && ($urandom_range(0, 2) == 0);
            @(negedge clk);
            start = 1'b0;
         end
      end
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      n = 0;
      while (bus.byte_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         n_cmp++;
         n_bad++;
         $display("FAIL byte_timeout: byte_ready got 0 want 1");
      end
      @(negedge clk);
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'($urandom);
   endtask

   task automatic fill_img(input int cnt, input logic [31:0] w0, w1, w2);
      img.delete();
      for (int i = 0; i < ((cnt <= DEPTH) ? cnt : 0); i++)
         img.push_back(i == 0 ? w0 : i == 1 ? w1 : i == 2 ? w2 :
                       (32'(i) * 32'h01010101) ^ 32'hA5A5_0000);
   endtask

   task automatic run_load(input string nm, input int cnt, input bit exp_done, input int exp_writes);
      logic [7:0] x;
      int m;
      qa.delete();
      qd.delete();
      mid = 1'b0;
      pulse_start();
      chk({nm, "_start_cpu_rst"}, 32'(cpu_rst), 1);
      chk({nm, "_start_done"},    32'(done), 0);
      chk({nm, "_start_err"},     32'(err), 0);
      mid = 1'b1;
      x = 8'h00;
      send_byte(cnt[7:0]);
      send_byte(cnt[15:8]);
      if (cnt <= DEPTH) begin
         for (int i = 0; i < cnt; i++)
            for (int k = 0; k < 4; k++) begin
               send_byte(img[i][8*k +: 8]);
               x ^= img[i][8*k +: 8];
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
         send_byte(x ^ cks_flip);
`endif
      end
      mid = 1'b0;
      repeat (2) @(negedge clk);
      chk({nm, "_done"},    32'(done), 32'(exp_done));
      chk({nm, "_err"},     32'(err), 32'(!exp_done));
      chk({nm, "_cpu_rst"}, 32'(cpu_rst), 32'(!exp_done));
      chk({nm, "_nwrites"}, qa.size(), exp_writes);
      m = (qa.size() < exp_writes) ? qa.size() : exp_writes;
      for (int i = 0; i < m; i++) begin
         chk({nm, "_waddr"}, 32'(qa[i]), i);
         chk({nm, "_wdata"}, qd[i], img[i]);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run got stuck want finished");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[$];
      int cnt;
      bit ok;

      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk_reset_vals("idle");

      vt.push_back('{3,   32'h00500093, 32'h00A00113, 32'h002081B3, 1'b0, 1'b1, 3});
      vt.push_back('{0,   32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 0});
      vt.push_back('{65,  32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 0});
      vt.push_back('{1,   32'hDEADBEEF, 32'h0,        32'h0,        1'b0, 1'b1, 1});
      vt.push_back('{256, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 0});
      vt.push_back('{64,  32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 1'b0, 1'b1, 64});
      vt.push_back('{3,   32'h00500093, 32'h00A00113, 32'h002081B3, 1'b1, 1'b1, 3});
      foreach (vt[v]) begin
         gaps = vt[v].gap;
         fill_img(vt[v].cnt, vt[v].w0, vt[v].w1, vt[v].w2);
         run_load($sformatf("vec%0d", v), vt[v].cnt, vt[v].exp_done, vt[v].exp_writes);
      end

      // Reset after two words of a four-word load.
      gaps = 1'b0;
      fill_img(4, 32'h11111111, 32'h22222222, 32'h33333333);
      qa.delete();
      qd.delete();
      pulse_start();
      send_byte(8'd4);
      send_byte(8'd0);
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < 4; k++) send_byte(img[i][8*k +: 8]);
      @(negedge clk);
      chk("midrst_nwrites", qa.size(), 2);
      chk("midrst_word1", (qd.size() > 1) ? qd[1] : 32'hX, 32'h22222222);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_load("reload", 4, 1'b1, 4);

`ifdef IMEM_BOOT_CHECKSUM_EN
      fill_img(1, 32'h11223344, 32'h0, 32'h0);
      cks_flip = 8'h00;
      run_load("cks_ok", 1, 1'b1, 1);
      cks_flip = 8'h01;
      run_load("cks_bad", 1, 1'b0, 1);
      cks_flip = 8'h00;
`endif

      // Randomized gapped loads with start pulses mid-load.
      gaps = 1'b1;
      for (int r = 0; r < 8; r++) begin
         cnt = (r == 7) ? $urandom_range(60, 70) : $urandom_range(1, 8);
         img.delete();
         for (int i = 0; i < ((cnt <= DEPTH) ? cnt : 0); i++) img.push_back($urandom);
         ok = (cnt <= DEPTH);
         run_load($sformatf("rnd%0d", r), cnt, ok, ok ? cnt : 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Hardware instruction-memory loader for the single-cycle RISC-V core. It accepts a byte stream (UART-receiver or host-FIFO side) carrying a word count and little-endian instruction words. It writes those words into instruction memory starting at word address 0, and holds the CPU in reset until the image is complete. Synthesizable programs are loaded this way; no simulation-only file load is needed.

## Interface
- `DEPTH`, 64: instruction-memory depth in 32-bit words (power of two, ≤ 65535).
- `ADDR_W`, 6: word-address width; must equal clog2(DEPTH).

- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse; begins a load from IDLE, DONE or ERR; ignored otherwise.
- `byte_valid` input 1: `byte_data` valid.
- `byte_data` input 8: stream byte.
- `byte_ready` output 1: loader accepts a byte this cycle; a transfer occurs when `byte_valid && byte_ready`.
- `imem_we` output 1: one-cycle instruction-memory write strobe.
- `imem_waddr` output ADDR_W: word address for the write.
- `imem_wdata` output 32: instruction word.
- `cpu_rst` output 1: active-high reset to `cpu_single_cycle`; high while not DONE.
- `done` output 1: image loaded; level signal.
- `err` output 1: load aborted; level signal.

## Operation
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, (CHK), DONE, ERR.
- IDLE → LEN_LO on `start`.
- LEN_LO: the accepted byte becomes count[7:0]; go to LEN_HI.
- LEN_HI: the accepted byte becomes count[15:8].
  - count == 0 → DONE (or CHK if the checksum feature is on).
  - count > DEPTH → ERR.
  - Otherwise → DATA with word index 0 and byte lane 0.
- DATA: byte lane k (0..3) fills word bits [8k+7:8k], so the first byte is the LSB. After lane 3 is accepted → WRITE.
- WRITE: one cycle.
  - `imem_we` = 1, `imem_waddr` = word index, `imem_wdata` = assembled word.
  - Word index increments.
  - If the index now equals count → DONE (or CHK); else → DATA.
- DONE: `cpu_rst` = 0, `done` = 1. `start` → LEN_LO and re-asserts `cpu_rst` in the same edge.
- ERR: `cpu_rst` = 1, `err` = 1. `start` → LEN_LO and clears `err`.
- `start` in LEN_LO, LEN_HI, DATA, WRITE or CHK is ignored.
- Byte counter is 2 bits and wraps 3 → 0. Word index width is ADDR_W+1 so that count == DEPTH is reachable.

## Timing
- Reset values: state IDLE, `byte_ready` 0, `imem_we` 0, `imem_waddr` 0, `imem_wdata` 0, `cpu_rst` 1, `done` 0, `err` 0.
- All outputs are registered or decoded from state. `byte_ready` is 1 only in LEN_LO, LEN_HI, DATA and CHK.
- Back-to-back bytes are accepted at 1 byte/cycle. `byte_valid` low stalls with no state change.
- `imem_we` fires in the cycle after the 4th byte of a word is accepted. `byte_ready` is 0 during that cycle.
- Throughput: 5 cycles per word with continuous input.
- `cpu_rst` falls on the same edge that enters DONE.
- Reset mid-load: immediate return to IDLE and reset values. Partial memory contents are left as written. `cpu_rst` stays 1.
- A byte with `byte_valid` high while `byte_ready` is low is not consumed; the source must hold it.

## Configuration
- `IMEM_BOOT_CHECKSUM_EN` defined:
  - After the last word (or after a count of 0), state CHK accepts one byte.
  - The expected value is the XOR of all data bytes; the length bytes are excluded.
  - Match → DONE. Mismatch → ERR.
  - The running XOR clears on `start`.
- Not defined: CHK does not exist and the last WRITE goes directly to DONE. No trailing byte is consumed.

## Test plan
- Load count=3, words 0x00500093, 0x00A00113, 0x002081B3: three `imem_we` pulses at addresses 0,1,2 with exactly those words. `done`=1, `cpu_rst`=0. The CPU then computes x3 = 15.
- count=0: DONE immediately after LEN_HI with no `imem_we` (checksum build: send 0x00 → DONE).
- count=DEPTH+1 (65): `err`=1 after the 2nd byte, no write, `cpu_rst` stays 1. A subsequent `start` plus a valid image → `done`=1, `err`=0.
- Random `byte_valid` gaps plus `start` pulses mid-load: the written words are identical to the gap-free run and `start` has no effect.
- Assert `rst_n` low after 2 words of a 4-word load: all outputs return to reset values immediately. Reload works.
- `IMEM_BOOT_CHECKSUM_EN`, one word 0x11223344 then checksum 0x44 (0x11^0x22^0x33^0x44 = 0x44): `done`=1. A checksum of 0x45 gives `err`=1 and `cpu_rst`=1.
